// File: rtl/jzjpcc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jzjpcc_pkg
// Description : Shared types and constants for the jzjpcc memory stage:
//               load funct3 encodings, memory FSM state type and the
//               load-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package jzjpcc_pkg;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Memory access FSM
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // A word load must sit on offset 0; a halfword load may not straddle the
  // word boundary (offset 3). Byte loads and unknown funct3 never fault.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    if (funct3 == LW)
      bad = (offset != 2'd0);
    else if ((funct3 == LH) || (funct3 == LHU))
      bad = (offset == 2'd3);
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jzjpcc_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : jzjpcc_memory_if
// Description : Execute -> memory stage bundle. The first group is registered
//               by execute; the store group is execute-cycle combinational
//               and is captured by the memory stage itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface jzjpcc_memory_if;

  // Registered by execute
  logic [31:0] aluResult;
  logic [4:0]  rdAddr;
  logic        rdSource;
  logic        rdWriteEnable;
  logic [2:0]  funct3;

  // Execute-cycle combinational store information
  logic        memoryWriteEnable;
  logic [31:2] memAddress;
  logic [31:0] memDataToWrite;
  logic [3:0]  memByteMask;

  // Producer side (execute stage)
  modport execute (
    output aluResult, rdAddr, rdSource, rdWriteEnable, funct3,
    output memoryWriteEnable, memAddress, memDataToWrite, memByteMask
  );

  // Consumer side (memory stage)
  modport memory (
    input aluResult, rdAddr, rdSource, rdWriteEnable, funct3,
    input memoryWriteEnable, memAddress, memDataToWrite, memByteMask
  );

endinterface
`default_nettype wire

// File: rtl/jzjpcc_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : jzjpcc_load_extract
// Description : Selects the addressed byte/halfword from a loaded word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module jzjpcc_load_extract
  import jzjpcc_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] value_o
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Lane selection and extension; offset 3 halfwords are filtered out upstream
  always_comb begin
    byteSel = word_i[{offset_i, 3'b000} +: 8];
    halfSel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    value_o = word_i;
    case (funct3_i)
      LB:      value_o = {{24{byteSel[7]}}, byteSel};
      LBU:     value_o = {24'h000000, byteSel};
      LH:      value_o = {{16{halfSel[15]}}, halfSel};
      LHU:     value_o = {16'h0000, halfSel};
      default: value_o = word_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/jzjpcc_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : jzjpcc_memory_stage
// Description : Memory stage of the jzjpcc pipeline. Issues loads/stores over
//               a req/ack data-memory handshake with bounded wait states,
//               stalls the front of the pipe while an access is pending,
//               extracts load data and registers the rd result to writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module jzjpcc_memory_stage
  import jzjpcc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
)(
  input  logic                   clock,
  input  logic                   reset,
  jzjpcc_memory_if.memory        memoryIF,

  output logic                   dmemReq,
  output logic                   dmemWriteEnable,
  output logic [29:0]            dmemAddr,
  output logic [31:0]            dmemWriteData,
  output logic [3:0]             dmemByteMask,
  input  logic                   dmemAck,
  input  logic [31:0]            dmemReadData,

  output logic                   memoryStall,
  output logic                   memFault,

  output logic [4:0]             rdAddr_memory,
  output logic                   rdWriteEnable_memory,
  output logic [31:0]            bypassValue_memory,

  output logic [4:0]             rdAddr_writeback,
  output logic                   rdWriteEnable_writeback,
  output logic [31:0]            rdValue_writeback
);

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  mem_state_t  state_q, state_d;
  logic [7:0]  waitCount_q, waitCount_d;

  logic        storeEn_q;
  logic [31:0] storeData_q;
  logic [3:0]  storeMask_q;

  logic        rdWe_wb_q;
  logic [4:0]  rdAddr_wb_q;
  logic [31:0] rdValue_wb_q;
  logic        memFault_q;

  logic        isLoad;
  logic        misaligned;
  logic        access;
  logic        reqComb;
  logic        stallComb;
  logic        abort;
  logic        fault;
  logic [31:0] loadValue;

  // The word address is taken from aluResult; the execute-side copy is not
  // needed here.
  logic        unused_memAddress;
  assign unused_memAddress = ^memoryIF.memAddress;

  // A store takes precedence; a load is only an access if it writes rd
  assign isLoad     = memoryIF.rdSource & memoryIF.rdWriteEnable;
  assign misaligned = !storeEn_q & isLoad &
                      load_misaligned(memoryIF.funct3, memoryIF.aluResult[1:0]);
  assign access     = (storeEn_q | isLoad) & !misaligned;

  // Next-state and handshake decode; abort is the cycle WAIT runs out
  always_comb begin
    state_d     = state_q;
    waitCount_d = waitCount_q;
    reqComb     = 1'b0;
    stallComb   = 1'b0;
    abort       = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          reqComb = 1'b1;
          if (!dmemAck) begin
            stallComb   = 1'b1;
            state_d     = WAIT;
            waitCount_d = 8'd1;
          end
        end
      end
      WAIT: begin
        if (dmemAck) begin
          reqComb     = 1'b1;
          state_d     = IDLE;
          waitCount_d = 8'd0;
        end else if (waitCount_q < WAIT_LIMIT) begin
          reqComb     = 1'b1;
          stallComb   = 1'b1;
          waitCount_d = waitCount_q + 8'd1;
        end else begin
          abort       = 1'b1;
          state_d     = IDLE;
          waitCount_d = 8'd0;
        end
      end
      default: begin
        state_d     = IDLE;
        waitCount_d = 8'd0;
      end
    endcase
  end

  // Request and stall drop the instant reset asserts, independent of state
  assign dmemReq     = reset & reqComb;
  assign memoryStall = reset & stallComb;
  assign fault       = misaligned | abort;

  assign dmemWriteEnable = storeEn_q;
  assign dmemAddr        = memoryIF.aluResult[31:2];
  assign dmemWriteData   = storeData_q;
  assign dmemByteMask    = storeMask_q;

  assign rdAddr_memory        = memoryIF.rdAddr;
  assign rdWriteEnable_memory = memoryIF.rdWriteEnable;
  assign bypassValue_memory   = memoryIF.aluResult;

  jzjpcc_load_extract u_load_extract (
    .funct3_i (memoryIF.funct3),
    .offset_i (memoryIF.aluResult[1:0]),
    .word_i   (dmemReadData),
    .value_o  (loadValue)
  );

  // FSM state and wait counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      waitCount_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      waitCount_q <= waitCount_d;
    end
  end

  // Store-side capture, frozen together with the execute registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      storeEn_q   <= 1'b0;
      storeData_q <= 32'h0;
      storeMask_q <= 4'h0;
    end else if (!memoryStall) begin
      storeEn_q   <= memoryIF.memoryWriteEnable;
      storeData_q <= memoryIF.memDataToWrite;
      storeMask_q <= memoryIF.memByteMask;
    end
  end

  // Writeback register: bubble while stalled, suppress rd on a fault
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdWe_wb_q    <= 1'b0;
      rdAddr_wb_q  <= 5'd0;
      rdValue_wb_q <= 32'h0;
      memFault_q   <= 1'b0;
    end else begin
      memFault_q <= fault;
      if (memoryStall) begin
        rdWe_wb_q <= 1'b0;
      end else begin
        rdWe_wb_q    <= memoryIF.rdWriteEnable & !fault;
        rdAddr_wb_q  <= memoryIF.rdAddr;
        rdValue_wb_q <= memoryIF.rdSource ? loadValue : memoryIF.aluResult;
      end
    end
  end

  assign rdWriteEnable_writeback = rdWe_wb_q;
  assign rdAddr_writeback        = rdAddr_wb_q;
  assign rdValue_writeback       = rdValue_wb_q;
  assign memFault                = memFault_q;

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_memory_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_jzjpcc_memory_stage
// Description : Directed bench for jzjpcc_memory_stage: single-cycle load/ALU
//               vector table plus hand sequences for wait states, timeout
//               abort and reset during an outstanding access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jzjpcc_memory_stage;
  import jzjpcc_pkg::*;

  localparam int unsigned MAX_WAIT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        dmemReq, dmemWriteEnable, dmemAck;
  logic [29:0] dmemAddr;
  logic [31:0] dmemWriteData, dmemReadData;
  logic [3:0]  dmemByteMask;
  logic        memoryStall, memFault;
  logic [4:0]  rdAddr_memory, rdAddr_writeback;
  logic        rdWriteEnable_memory, rdWriteEnable_writeback;
  logic [31:0] bypassValue_memory, rdValue_writeback;

  jzjpcc_memory_if mif ();

  jzjpcc_memory_stage #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .memoryIF                (mif),
    .dmemReq                 (dmemReq),
    .dmemWriteEnable         (dmemWriteEnable),
    .dmemAddr                (dmemAddr),
    .dmemWriteData           (dmemWriteData),
    .dmemByteMask            (dmemByteMask),
    .dmemAck                 (dmemAck),
    .dmemReadData            (dmemReadData),
    .memoryStall             (memoryStall),
    .memFault                (memFault),
    .rdAddr_memory           (rdAddr_memory),
    .rdWriteEnable_memory    (rdWriteEnable_memory),
    .bypassValue_memory      (bypassValue_memory),
    .rdAddr_writeback        (rdAddr_writeback),
    .rdWriteEnable_writeback (rdWriteEnable_writeback),
    .rdValue_writeback       (rdValue_writeback)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        src;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        ack;
    logic        expReq;
    logic        expWbWe;
    logic [31:0] expVal;
    logic        expFault;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [31:0] alu, input logic [4:0] rd,
                              input logic src, input logic we,
                              input logic [2:0] f3, input logic [31:0] rdata,
                              input logic ack, input logic expReq,
                              input logic expWbWe, input logic [31:0] expVal,
                              input logic expFault);
    vec_t v;
    v.alu = alu; v.rd = rd; v.src = src; v.we = we; v.f3 = f3;
    v.rdata = rdata; v.ack = ack; v.expReq = expReq; v.expWbWe = expWbWe;
    v.expVal = expVal; v.expFault = expFault;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] alu, input logic [4:0] rd,
                           input logic src, input logic we,
                           input logic [2:0] f3);
    mif.aluResult     = alu;
    mif.rdAddr        = rd;
    mif.rdSource      = src;
    mif.rdWriteEnable = we;
    mif.funct3        = f3;
  endtask

  // One instruction per cycle; ack (if any) comes in the same cycle
  task automatic run_vec(input vec_t v, input int idx);
    set_instr(v.alu, v.rd, v.src, v.we, v.f3);
    dmemAck      = v.ack;
    dmemReadData = v.rdata;
    @(negedge clock);
    check($sformatf("v%0d_req", idx), dmemReq, v.expReq);
    check($sformatf("v%0d_stall", idx), memoryStall, 1'b0);
    check($sformatf("v%0d_rdmem", idx), rdAddr_memory, v.rd);
    if (v.expReq) begin
      check($sformatf("v%0d_addr", idx), dmemAddr, v.alu[31:2]);
      check($sformatf("v%0d_dwe", idx), dmemWriteEnable, 1'b0);
    end
    @(posedge clock); #1;
    check($sformatf("v%0d_wbwe", idx), rdWriteEnable_writeback, v.expWbWe);
    check($sformatf("v%0d_fault", idx), memFault, v.expFault);
    if (v.expWbWe) begin
      check($sformatf("v%0d_wbval", idx), rdValue_writeback, v.expVal);
      check($sformatf("v%0d_wbaddr", idx), rdAddr_writeback, v.rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;

    vecs[0]  = mk(32'h0000_0100, 5'd5,  1, 1, LW,     32'hDEAD_BEEF, 1, 1, 1, 32'hDEAD_BEEF, 0);
    vecs[1]  = mk(32'h0000_0103, 5'd6,  1, 1, LB,     32'h80FF_0000, 1, 1, 1, 32'hFFFF_FF80, 0);
    vecs[2]  = mk(32'h0000_0103, 5'd6,  1, 1, LBU,    32'h80FF_0000, 1, 1, 1, 32'h0000_0080, 0);
    vecs[3]  = mk(32'h0000_0102, 5'd7,  1, 1, LHU,    32'h80FF_0000, 1, 1, 1, 32'h0000_80FF, 0);
    vecs[4]  = mk(32'h0000_0102, 5'd7,  1, 1, LH,     32'h80FF_0000, 1, 1, 1, 32'hFFFF_80FF, 0);
    vecs[5]  = mk(32'h0000_0101, 5'd8,  1, 1, LH,     32'h1234_F00D, 1, 1, 1, 32'hFFFF_F00D, 0);
    vecs[6]  = mk(32'h0000_0101, 5'd8,  1, 1, LB,     32'h1234_F00D, 1, 1, 1, 32'hFFFF_FFF0, 0);
    vecs[7]  = mk(32'h0000_0100, 5'd9,  1, 1, LHU,    32'h1234_F00D, 1, 1, 1, 32'h0000_F00D, 0);
    vecs[8]  = mk(32'hCAFE_0001, 5'd10, 0, 1, LW,     32'h0000_0000, 0, 0, 1, 32'hCAFE_0001, 0);
    vecs[9]  = mk(32'h0000_0102, 5'd11, 1, 1, LW,     32'h1234_5678, 0, 0, 0, 32'h0,         1);
    vecs[10] = mk(32'h0000_0107, 5'd12, 1, 1, LH,     32'h1234_5678, 0, 0, 0, 32'h0,         1);
    vecs[11] = mk(32'h0000_010B, 5'd13, 1, 1, LHU,    32'h1234_5678, 0, 0, 0, 32'h0,         1);
    vecs[12] = mk(32'h0000_010E, 5'd14, 1, 1, 3'b011, 32'h1122_3344, 1, 1, 1, 32'h1122_3344, 0);
    vecs[13] = mk(32'h0000_010C, 5'd15, 1, 1, LBU,    32'h1122_3344, 1, 1, 1, 32'h0000_0044, 0);
    vecs[14] = mk(32'h0000_0110, 5'd16, 1, 0, LW,     32'hFFFF_FFFF, 1, 0, 0, 32'h0,         0);
    vecs[15] = mk(32'h1234_5678, 5'd17, 0, 1, LB,     32'h0000_0000, 1, 0, 1, 32'h1234_5678, 0);
    vecs[16] = mk(32'h0000_010A, 5'd18, 1, 1, LBU,    32'hA1B2_C3D4, 1, 1, 1, 32'h0000_00B2, 0);

    // Reset state
    reset = 1'b0;
    set_instr(32'h0, 5'd0, 0, 0, LB);
    mif.memoryWriteEnable = 1'b0;
    mif.memAddress        = 30'h0;
    mif.memDataToWrite    = 32'h0;
    mif.memByteMask       = 4'h0;
    dmemAck               = 1'b0;
    dmemReadData          = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_req",   dmemReq, 1'b0);
    check("rst_stall", memoryStall, 1'b0);
    check("rst_fault", memFault, 1'b0);
    check("rst_wbwe",  rdWriteEnable_writeback, 1'b0);
    check("rst_wbadr", rdAddr_writeback, 5'd0);
    check("rst_wbval", rdValue_writeback, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

    // Store with three wait cycles; capture must hold while stalled
    dmemAck = 1'b0;
    set_instr(32'h0000_1111, 5'd3, 0, 1, LW);
    mif.memoryWriteEnable = 1'b1;
    mif.memDataToWrite    = 32'hA5A5_1234;
    mif.memByteMask       = 4'b0011;
    @(posedge clock); #1;
    check("st_pre_wbval", rdValue_writeback, 32'h0000_1111);
    set_instr(32'h0000_0200, 5'd0, 0, 0, LW);
    mif.memoryWriteEnable = 1'b0;
    mif.memDataToWrite    = 32'hFFFF_FFFF;
    mif.memByteMask       = 4'hF;
    stalls = 0;
    for (int c = 0; c < 4; c++) begin
      dmemAck = (c == 3);
      @(negedge clock);
      if (memoryStall) stalls++;
      check($sformatf("st%0d_req", c),   dmemReq, 1'b1);
      check($sformatf("st%0d_we", c),    dmemWriteEnable, 1'b1);
      check($sformatf("st%0d_addr", c),  dmemAddr, 30'h80);
      check($sformatf("st%0d_data", c),  dmemWriteData, 32'hA5A5_1234);
      check($sformatf("st%0d_mask", c),  dmemByteMask, 4'b0011);
      check($sformatf("st%0d_stall", c), memoryStall, (c < 3));
      @(posedge clock); #1;
      check($sformatf("st%0d_wbwe", c),  rdWriteEnable_writeback, 1'b0);
      check($sformatf("st%0d_fault", c), memFault, 1'b0);
    end
    check("st_stall_count", stalls, 3);
    dmemAck = 1'b0;
    set_instr(32'h0000_2222, 5'd4, 0, 1, LW);
    @(negedge clock);
    check("st_post_req", dmemReq, 1'b0);
    @(posedge clock); #1;
    check("st_post_wbwe",  rdWriteEnable_writeback, 1'b1);
    check("st_post_wbval", rdValue_writeback, 32'h0000_2222);

    // Load that is never acknowledged: abort after MAX_WAIT wait cycles
    set_instr(32'h0000_0300, 5'd7, 1, 1, LW);
    stalls = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (memoryStall) stalls++;
      check($sformatf("ab%0d_req", c),   dmemReq, (c < 4));
      check($sformatf("ab%0d_stall", c), memoryStall, (c < 4));
      @(posedge clock); #1;
      check($sformatf("ab%0d_fault", c), memFault, (c == 4));
      check($sformatf("ab%0d_wbwe", c),  rdWriteEnable_writeback, 1'b0);
    end
    check("ab_stall_count", stalls, 4);
    set_instr(32'h0000_3333, 5'd8, 0, 1, LW);
    @(posedge clock); #1;
    check("ab_post_fault", memFault, 1'b0);
    check("ab_post_wbwe",  rdWriteEnable_writeback, 1'b1);
    check("ab_post_wbval", rdValue_writeback, 32'h0000_3333);
    check("ab_post_wbadr", rdAddr_writeback, 5'd8);

    // Reset asserted during the second WAIT cycle
    set_instr(32'h0000_0400, 5'd9, 1, 1, LW);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rw_req_before", dmemReq, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rw_req",   dmemReq, 1'b0);
    check("rw_stall", memoryStall, 1'b0);
    check("rw_fault", memFault, 1'b0);
    check("rw_wbwe",  rdWriteEnable_writeback, 1'b0);
    check("rw_wbadr", rdAddr_writeback, 5'd0);
    check("rw_wbval", rdValue_writeback, 32'h0);
    set_instr(32'h0, 5'd0, 0, 0, LB);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    // Late ack arrives with only an ALU instruction in the stage
    dmemAck      = 1'b1;
    dmemReadData = 32'h5555_5555;
    set_instr(32'h0000_4444, 5'd10, 0, 1, LW);
    @(negedge clock);
    check("rw_late_req",   dmemReq, 1'b0);
    check("rw_late_stall", memoryStall, 1'b0);
    @(posedge clock); #1;
    check("rw_late_wbwe",  rdWriteEnable_writeback, 1'b1);
    check("rw_late_wbval", rdValue_writeback, 32'h0000_4444);
    check("rw_late_fault", memFault, 1'b0);
    dmemAck = 1'b0;
    run_vec(mk(32'h0000_0500, 5'd11, 1, 1, LW, 32'h0BAD_F00D, 1, 1, 1, 32'h0BAD_F00D, 0), 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
